instruction_fetch_unit: RTL and testbench

Fetch-stage producer for the IF/ID pipeline register. It holds the PC, runs the busywait-style read handshake with instruction memory, and presents the fetched word, its PC and PC+4 to IF/ID. Its BUSYWAIT output tells IF/ID when to hold. It also redirects on taken branches from EX, discarding any in-flight fetch that memory cannot abort.

---
 rtl/instruction_fetch_unit.sv | 137 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, busywait read handshake with instruction memory, IF/ID output slot, branch redirect.
// Optional IFU_NOP_FLUSH_EN: reset/flush load INSTRUCTION_OUT with addi x0,x0,0.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] INSTRUCTION_OUT,
    output logic [31:0] PC_DIRECT_OUT,
    output logic [31:0] PC_PLUS_4_OUT,
    output logic        BUSYWAIT
);

`ifdef IFU_NOP_FLUSH_EN
    localparam logic [31:0] FLUSH_WORD = 32'h0000_0013;
`else
    localparam logic [31:0] FLUSH_WORD = 32'h0000_0000;
`endif
    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_req_addr, w_req_addr_nxt;
    logic        r_out_valid, w_out_valid_nxt;
    logic [31:0] r_instr, w_instr_nxt;
    logic [31:0] r_pc_direct, w_pc_direct_nxt;
    logic [31:0] r_pc_plus4, w_pc_plus4_nxt;

    logic        w_consume;
    logic        w_complete;
    logic [31:0] w_target;
    logic [31:0] w_req_plus4;

    assign IMEM_READ       = (r_state != S_IDLE);
    assign IMEM_ADDRESS    = r_req_addr;
    assign INSTRUCTION_OUT = r_instr;
    assign PC_DIRECT_OUT   = r_pc_direct;
    assign PC_PLUS_4_OUT   = r_pc_plus4;
    assign BUSYWAIT        = !r_out_valid || STALL;

    assign w_consume   = r_out_valid && !STALL;
    assign w_complete  = IMEM_READ && !IMEM_BUSYWAIT;
    assign w_target    = BRANCH_TARGET & 32'hFFFF_FFFC;
    assign w_req_plus4 = r_req_addr + 32'd4;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_pc        <= PC_INIT;
            r_req_addr  <= PC_INIT;
            r_out_valid <= 1'b0;
            r_instr     <= FLUSH_WORD;
            r_pc_direct <= 32'h0;
            r_pc_plus4  <= 32'h0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_req_addr  <= w_req_addr_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_instr     <= w_instr_nxt;
            r_pc_direct <= w_pc_direct_nxt;
            r_pc_plus4  <= w_pc_plus4_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_req_addr_nxt  = r_req_addr;
        w_out_valid_nxt = r_out_valid && !w_consume;
        w_instr_nxt     = r_instr;
        w_pc_direct_nxt = r_pc_direct;
        w_pc_plus4_nxt  = r_pc_plus4;

        if (BRANCH_TAKEN) begin
            // Redirect wins over stall and completion; a busy request is never abandoned.
            w_pc_nxt        = w_target;
            w_out_valid_nxt = 1'b0;
`ifdef IFU_NOP_FLUSH_EN
            w_instr_nxt     = FLUSH_WORD;
`endif
            unique case (r_state)
                S_IDLE: begin
                    w_req_addr_nxt = w_target;
                    w_state_nxt    = S_REQ;
                end
                S_REQ: begin
                    if (w_complete) begin
                        w_req_addr_nxt = w_target;
                        w_state_nxt    = S_REQ;
                    end else begin
                        w_state_nxt    = S_DISCARD;
                    end
                end
                S_DISCARD: w_state_nxt = S_DISCARD;
                default:   w_state_nxt = S_IDLE;
            endcase
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    // Launch only into an empty slot so a completion never overwrites live data.
                    if (!r_out_valid || w_consume) begin
                        w_req_addr_nxt = r_pc;
                        w_state_nxt    = S_REQ;
                    end
                end
                S_REQ: begin
                    if (w_complete) begin
                        w_instr_nxt     = IMEM_READDATA;
                        w_pc_direct_nxt = r_req_addr;
                        w_pc_plus4_nxt  = w_req_plus4;
                        w_out_valid_nxt = 1'b1;
                        w_pc_nxt        = w_req_plus4;
                        w_state_nxt     = S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (w_complete) begin
                        w_req_addr_nxt = r_pc;
                        w_state_nxt    = S_REQ;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: handshake, wait states, stall, branch/discard, wrap, async reset.
module tb_instruction_fetch_unit;

`ifdef IFU_NOP_FLUSH_EN
    localparam logic [31:0] FLUSH = 32'h0000_0013;
`else
    localparam logic [31:0] FLUSH = 32'h0000_0000;
`endif

    logic        CLK;
    logic        RESET_N;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] INSTRUCTION_OUT;
    logic [31:0] PC_DIRECT_OUT;
    logic [31:0] PC_PLUS_4_OUT;
    logic        BUSYWAIT;

    // second instance for the RESET_PC wrap case
    logic        w_rst_n;
    logic        w_zero;
    logic [31:0] w_tgt;
    logic        w_read;
    logic [31:0] w_addr;
    logic [31:0] w_rdata;
    logic [31:0] w_instr;
    logic [31:0] w_pcd;
    logic [31:0] w_pc4;
    logic        w_bw;

    int n_chk  = 0;
    int n_pass = 0;

    // memory model: word = AAAA_0001 + address
    assign IMEM_READDATA = 32'hAAAA_0001 + IMEM_ADDRESS;
    assign w_rdata       = 32'hAAAA_0001 + w_addr;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL),
        .BRANCH_TAKEN(BRANCH_TAKEN), .BRANCH_TARGET(BRANCH_TARGET),
        .IMEM_READ(IMEM_READ), .IMEM_ADDRESS(IMEM_ADDRESS),
        .IMEM_READDATA(IMEM_READDATA), .IMEM_BUSYWAIT(IMEM_BUSYWAIT),
        .INSTRUCTION_OUT(INSTRUCTION_OUT), .PC_DIRECT_OUT(PC_DIRECT_OUT),
        .PC_PLUS_4_OUT(PC_PLUS_4_OUT), .BUSYWAIT(BUSYWAIT)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .CLK(CLK), .RESET_N(w_rst_n), .STALL(w_zero),
        .BRANCH_TAKEN(w_zero), .BRANCH_TARGET(w_tgt),
        .IMEM_READ(w_read), .IMEM_ADDRESS(w_addr),
        .IMEM_READDATA(w_rdata), .IMEM_BUSYWAIT(w_zero),
        .INSTRUCTION_OUT(w_instr), .PC_DIRECT_OUT(w_pcd),
        .PC_PLUS_4_OUT(w_pc4), .BUSYWAIT(w_bw)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET_N = 1'b0; STALL = 1'b0; BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
        IMEM_BUSYWAIT = 1'b0;
        w_rst_n = 1'b0; w_zero = 1'b0; w_tgt = 32'h0;
        tick(); tick();
        chk("rst_read",  {31'h0, IMEM_READ}, 32'h0);
        chk("rst_addr",  IMEM_ADDRESS, 32'h0);
        chk("rst_bw",    {31'h0, BUSYWAIT}, 32'h1);
        chk("rst_instr", INSTRUCTION_OUT, FLUSH);
        chk("rst_pcd",   PC_DIRECT_OUT, 32'h0);
        chk("rst_pc4",   PC_PLUS_4_OUT, 32'h0);

        RESET_N = 1'b1;
        tick();  // IDLE -> REQ at 0x0
        chk("f0_read", {31'h0, IMEM_READ}, 32'h1);
        chk("f0_addr", IMEM_ADDRESS, 32'h0);
        chk("f0_bw",   {31'h0, BUSYWAIT}, 32'h1);
        tick();  // zero-wait completion
        chk("f0_instr", INSTRUCTION_OUT, 32'hAAAA_0001);
        chk("f0_pcd",   PC_DIRECT_OUT, 32'h0);
        chk("f0_pc4",   PC_PLUS_4_OUT, 32'h4);
        chk("f0_bw",    {31'h0, BUSYWAIT}, 32'h0);
        chk("f0_idle",  {31'h0, IMEM_READ}, 32'h0);

        tick();  // consume, request 0x4
        chk("f1_addr", IMEM_ADDRESS, 32'h4);
        IMEM_BUSYWAIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("ws_read", {31'h0, IMEM_READ}, 32'h1);
            chk("ws_addr", IMEM_ADDRESS, 32'h4);
            chk("ws_bw",   {31'h0, BUSYWAIT}, 32'h1);
            tick();
        end
        chk("ws_read4", {31'h0, IMEM_READ}, 32'h1);
        chk("ws_addr4", IMEM_ADDRESS, 32'h4);
        IMEM_BUSYWAIT = 1'b0;
        tick();  // completion at 0x4
        chk("f1_instr", INSTRUCTION_OUT, 32'hAAAA_0005);
        chk("f1_pcd",   PC_DIRECT_OUT, 32'h4);
        chk("f1_pc4",   PC_PLUS_4_OUT, 32'h8);
        chk("f1_bw",    {31'h0, BUSYWAIT}, 32'h0);

        STALL = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("st_instr", INSTRUCTION_OUT, 32'hAAAA_0005);
            chk("st_pcd",   PC_DIRECT_OUT, 32'h4);
            chk("st_read",  {31'h0, IMEM_READ}, 32'h0);
            chk("st_bw",    {31'h0, BUSYWAIT}, 32'h1);
        end
        STALL = 1'b0;
        #1;
        chk("st_rel_bw", {31'h0, BUSYWAIT}, 32'h0);
        tick();  // consume, request 0x8 on this edge
        chk("f2_read", {31'h0, IMEM_READ}, 32'h1);
        chk("f2_addr", IMEM_ADDRESS, 32'h8);
        chk("f2_bw",   {31'h0, BUSYWAIT}, 32'h1);

        IMEM_BUSYWAIT = 1'b1;
        tick();
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h0000_0100;
        tick();  // branch while busy -> DISCARD
        BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
        chk("dis_read", {31'h0, IMEM_READ}, 32'h1);
        chk("dis_addr", IMEM_ADDRESS, 32'h8);
        tick();
        chk("dis_addr2", IMEM_ADDRESS, 32'h8);
        chk("dis_bw",    {31'h0, BUSYWAIT}, 32'h1);
        IMEM_BUSYWAIT = 1'b0;
        tick();  // discarded completion, re-request at target
        chk("dis_tgt",   IMEM_ADDRESS, 32'h100);
        chk("dis_read2", {31'h0, IMEM_READ}, 32'h1);
        chk("dis_bw2",   {31'h0, BUSYWAIT}, 32'h1);
`ifdef IFU_NOP_FLUSH_EN
        chk("dis_instr", INSTRUCTION_OUT, 32'h0000_0013);
`else
        chk("dis_instr", INSTRUCTION_OUT, 32'hAAAA_0005);
`endif
        tick();
        chk("f3_instr", INSTRUCTION_OUT, 32'hAAAA_0101);
        chk("f3_pcd",   PC_DIRECT_OUT, 32'h100);
        chk("f3_pc4",   PC_PLUS_4_OUT, 32'h104);
        chk("f3_bw",    {31'h0, BUSYWAIT}, 32'h0);

        tick();  // consume, request 0x104
        chk("f4_addr", IMEM_ADDRESS, 32'h104);
        BRANCH_TAKEN = 1'b1; BRANCH_TARGET = 32'h0000_0203;
        tick();  // branch coincides with completion
        BRANCH_TAKEN = 1'b0; BRANCH_TARGET = 32'h0;
        chk("bc_addr", IMEM_ADDRESS, 32'h200);
        chk("bc_read", {31'h0, IMEM_READ}, 32'h1);
        chk("bc_bw",   {31'h0, BUSYWAIT}, 32'h1);
`ifdef IFU_NOP_FLUSH_EN
        chk("bc_instr", INSTRUCTION_OUT, 32'h0000_0013);
`else
        chk("bc_instr", INSTRUCTION_OUT, 32'hAAAA_0101);
`endif
        tick();
        chk("f5_instr", INSTRUCTION_OUT, 32'hAAAA_0201);
        chk("f5_pcd",   PC_DIRECT_OUT, 32'h200);
        chk("f5_pc4",   PC_PLUS_4_OUT, 32'h204);

        tick();  // consume, request 0x204, then reset mid-request
        IMEM_BUSYWAIT = 1'b1;
        chk("mr_read", {31'h0, IMEM_READ}, 32'h1);
        chk("mr_addr", IMEM_ADDRESS, 32'h204);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("ar_read",  {31'h0, IMEM_READ}, 32'h0);
        chk("ar_addr",  IMEM_ADDRESS, 32'h0);
        chk("ar_instr", INSTRUCTION_OUT, FLUSH);
        chk("ar_pcd",   PC_DIRECT_OUT, 32'h0);
        chk("ar_pc4",   PC_PLUS_4_OUT, 32'h0);
        chk("ar_bw",    {31'h0, BUSYWAIT}, 32'h1);
        IMEM_BUSYWAIT = 1'b0;

        // wrap-around with RESET_PC = FFFF_FFFC
        tick();
        w_rst_n = 1'b1;
        tick();
        chk("wr_addr", w_addr, 32'hFFFF_FFFC);
        chk("wr_read", {31'h0, w_read}, 32'h1);
        tick();
        chk("wr_instr", w_instr, 32'hAAA9_FFFD);
        chk("wr_pcd",   w_pcd, 32'hFFFF_FFFC);
        chk("wr_pc4",   w_pc4, 32'h0);
        chk("wr_bw",    {31'h0, w_bw}, 32'h0);
        tick();
        chk("wr_next", w_addr, 32'h0);
        chk("wr_read2", {31'h0, w_read}, 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
